// File: rtl/watch_pkg.sv
// Shared constants for the watch button path: channel indices, default
// timing, and the auto-repeat hold states.
package watch_pkg;

   localparam int unsigned BTN_MODE  = 0;
   localparam int unsigned BTN_SET   = 1;
   localparam int unsigned BTN_INC   = 2;
   localparam int unsigned BTN_DEC   = 3;
   localparam int unsigned BTN_LIGHT = 4;

   localparam int unsigned N_BTN_DEF           = 5;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
   localparam int unsigned REPEAT_DELAY_DEF    = 32768;
   localparam int unsigned REPEAT_RATE_DEF     = 8192;
   localparam logic [4:0]  REPEAT_MASK_DEF     = 5'b01100;

   typedef enum logic {
      HOLD_DELAY  = 1'b0,
      HOLD_REPEAT = 1'b1
   } hold_state_e;

   // Bits needed to hold values 0..max_val; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce, press edge detect and
// optional auto-repeat while the accepted level stays high.
//
// state        | meaning
// HOLD_DELAY   | level held, waiting REPEAT_DELAY cycles for the first repeat
// HOLD_REPEAT  | repeating, one pulse every REPEAT_RATE cycles
module btn_channel
   import watch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int unsigned DW       = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned HW       = cnt_width(HOLD_MAX);

   localparam logic [DW-1:0] CNT_TC = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;
   logic          level_q;
   logic          level_d;
   logic          pulse_q;
   logic          pulse_d;
   logic          press;
   logic          repeat_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Any agreement between the synchronised input and the accepted level
   // restarts qualification, so only an unbroken mismatch run toggles level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_TC) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   assign press = level_d & ~level_q;

   generate
      if (REPEAT_EN) begin : g_rep
         logic [HW-1:0] hold_q;
         hold_state_e   rep_q;
         logic          run;
         logic          hold_tc;

         // Requiring level_d keeps a release that qualifies on a terminal
         // count from producing a trailing repeat.
         assign run = level_q & level_d;

         always_comb begin
            hold_tc = 1'b0;
            if (rep_q == HOLD_REPEAT) begin
               hold_tc = (hold_q == HW'(REPEAT_RATE - 1));
            end else begin
               hold_tc = (hold_q == HW'(REPEAT_DELAY - 1));
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               hold_q <= '0;
               rep_q  <= HOLD_DELAY;
            end else if (!run) begin
               hold_q <= '0;
               rep_q  <= HOLD_DELAY;
            end else if (hold_tc) begin
               hold_q <= '0;
               rep_q  <= HOLD_REPEAT;
            end else begin
               hold_q <= hold_q + HW'(1);
            end
         end

         assign repeat_evt = run & hold_tc;
      end else begin : g_norep
         assign repeat_evt = 1'b0;
      end
   endgenerate

   assign pulse_d = press | repeat_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw watch buttons into debounced levels and one-cycle press
// pulses; channels selected by REPEAT_MASK also auto-repeat while held.
module button_conditioner
   import watch_pkg::*;
#(
   parameter int unsigned      N_BTN           = N_BTN_DEF,
   parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned      REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned      REPEAT_RATE     = REPEAT_RATE_DEF,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = REPEAT_MASK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse
);

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_ch
         btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
         ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (btn_raw[i]),
            .level_o (btn_level[i]),
            .pulse_o (btn_pulse[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing overrides.
module tb_button_conditioner;

   localparam int D   = 4;
   localparam int RD  = 10;
   localparam int RR  = 3;
   localparam int LAT = D + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn_raw = 5'h1f;
   logic [4:0] btn_level;
   logic [4:0] btn_pulse;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;
   bit done    = 1'b0;

   typedef struct {
      int         cyc;
      logic [4:0] mask;
   } pexp_t;

   typedef struct {
      int         cyc;
      logic [4:0] mask;
      logic [4:0] val;
   } lexp_t;

   pexp_t pulse_q[$];
   lexp_t lvl_q[$];

   button_conditioner #(
      .N_BTN           (5),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR),
      .REPEAT_MASK     (5'b01100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected pulse at cycle c (sampled after edge c); same-cycle entries merge.
   function automatic void push_pulse(input int c, input logic [4:0] m);
      pexp_t e;
      e.cyc  = c;
      e.mask = m;
      for (int i = 0; i < pulse_q.size(); i++) begin
         if (pulse_q[i].cyc == c) begin
            pulse_q[i].mask = pulse_q[i].mask | m;
            return;
         end
         if (pulse_q[i].cyc > c) begin
            pulse_q.insert(i, e);
            return;
         end
      end
      pulse_q.push_back(e);
   endfunction

   function automatic void push_lvl(input int c, input logic [4:0] m, input logic [4:0] v);
      lexp_t e;
      e.cyc  = c;
      e.mask = m;
      e.val  = v;
      for (int i = 0; i < lvl_q.size(); i++) begin
         if (lvl_q[i].cyc > c) begin
            lvl_q.insert(i, e);
            return;
         end
      end
      lvl_q.push_back(e);
   endfunction

   // Raw asserted after edge pc, released after edge rc: press pulse LAT edges
   // later, repeats from pc+LAT+RD every RR while the release has not qualified.
   function automatic void sched(input int pc, input int rc, input logic [4:0] m, input bit rep);
      push_pulse(pc + LAT, m);
      if (rep) begin
         for (int t = pc + LAT + RD; t <= rc + LAT - 1; t += RR) begin
            push_pulse(t, m);
         end
      end
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge.
   always @(negedge clk) begin
      if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
         check("pulse", btn_pulse, pulse_q[0].mask);
         void'(pulse_q.pop_front());
      end else if (btn_pulse !== 5'b0) begin
         check("spurious_pulse", btn_pulse, 5'b0);
      end
      while (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
         check("level", btn_level & lvl_q[0].mask, lvl_q[0].val);
         void'(lvl_q.pop_front());
      end
      if (done) begin
         check("pending_pulses", 5'(pulse_q.size()), 5'd0);
         check("pending_levels", 5'(lvl_q.size()), 5'd0);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      // Reset with every button held, then requalify all five together.
      step(2);
      push_lvl(cyc, 5'h1f, 5'h00);
      rst = 1'b0;
      c   = cyc;
      sched(c, c + 8, 5'h13, 1'b0);
      sched(c, c + 8, 5'h0c, 1'b1);
      push_lvl(c + LAT - 1, 5'h1f, 5'h00);
      push_lvl(c + LAT,     5'h1f, 5'h1f);
      step(8);
      btn_raw = 5'h00;
      push_lvl(cyc + LAT, 5'h1f, 5'h00);
      step(LAT + 4);

      // Clean press and release on mode.
      c = cyc;
      btn_raw[0] = 1'b1;
      sched(c, c + 20, 5'h01, 1'b0);
      push_lvl(c + LAT - 1,      5'h01, 5'h00);
      push_lvl(c + LAT,          5'h01, 5'h01);
      push_lvl(c + 20 + LAT - 1, 5'h01, 5'h01);
      push_lvl(c + 20 + LAT,     5'h01, 5'h00);
      step(20);
      btn_raw[0] = 1'b0;
      step(LAT + 6);

      // Bounce on set: highs shorter than D never qualify.
      for (int k = 0; k < 5; k++) begin
         btn_raw[1] = 1'b1;
         step(3);
         btn_raw[1] = 1'b0;
         push_lvl(cyc + 3, 5'h02, 5'h00);
         step(3);
      end
      push_lvl(cyc + 2, 5'h02, 5'h00);
      step(2);
      c = cyc;
      btn_raw[1] = 1'b1;
      sched(c, c + 10, 5'h02, 1'b0);
      step(10);
      btn_raw[1] = 1'b0;
      step(LAT + 6);

      // Auto-repeat on inc alongside light, which must not repeat.
      c = cyc;
      btn_raw[2] = 1'b1;
      btn_raw[4] = 1'b1;
      sched(c, c + 30, 5'h04, 1'b1);
      sched(c, c + 30, 5'h10, 1'b0);
      push_lvl(c + 30, 5'h14, 5'h14);
      step(30);
      btn_raw[2] = 1'b0;
      btn_raw[4] = 1'b0;
      step(LAT + 6);

      // Inc and dec together; release qualifies on a repeat terminal count.
      c = cyc;
      btn_raw[3:2] = 2'b11;
      sched(c, c + 19, 5'h0c, 1'b1);
      push_lvl(c + 19 + LAT, 5'h0c, 5'h00);
      step(19);
      btn_raw[3:2] = 2'b00;
      step(LAT + 6);

      // Reset in the middle of an inc hold.
      c = cyc;
      btn_raw[2] = 1'b1;
      push_pulse(c + LAT, 5'h04);
      step(11);
      rst = 1'b1;
      step(1);
      push_lvl(cyc, 5'h1f, 5'h00);
      rst = 1'b0;
      sched(cyc, c + 25, 5'h04, 1'b1);
      push_lvl(cyc + LAT - 1, 5'h04, 5'h00);
      push_lvl(cyc + LAT,     5'h04, 5'h04);
      step(13);
      btn_raw[2] = 1'b0;
      step(LAT + 6);

      done = 1'b1;
   end

endmodule
